// File: rtl/ram_sync_clr.sv
// Single-clock RAM with lane write masks, selectable read-during-write policy
// and a sequencer that fills every word with CLEAR_VALUE after reset or on request.
module ram_sync_clr #(
   parameter int                   ADDR_BITS   = 8,
   parameter int                   DATA_BITS   = 8,
   parameter int                   LANES       = 1,
   parameter bit                   BYPASS      = 1'b1,
   parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_start,
   output logic                 busy,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic [LANES-1:0]     wr_mask
);

   localparam int DEPTH     = 2 ** ADDR_BITS;
   localparam int LANE_BITS = DATA_BITS / LANES;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;

   logic [DATA_BITS-1:0]   mem_q [DEPTH];

   logic                   mem_we;
   logic [ADDR_BITS-1:0]   mem_waddr;
   logic [DATA_BITS-1:0]   mem_wdata;
   logic [LANES-1:0]       mem_wmask;
   logic                   port_active;

   logic [DATA_BITS-1:0]   rd_word;
   logic [DATA_BITS-1:0]   rd_merged;
   logic                   bypass_hit;
   logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
   logic                   rd_valid_q, rd_valid_d;

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // The clear sequencer owns the single write port while it runs.
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      mem_we      = 1'b0;
      mem_waddr   = wr_addr;
      mem_wdata   = wr_data;
      mem_wmask   = wr_mask;
      port_active = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = CLEAR_VALUE;
            mem_wmask  = '1;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == {ADDR_BITS{1'b1}}) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            port_active = 1'b1;
            mem_we      = wr_en;
            if (clr_start) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   assign busy = (state_q == ST_CLEAR);

   // ------------------------------------------------------------------
   // Storage: reset never writes, it only restarts the sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int li = 0; li < LANES; li++) begin
            if (mem_wmask[li]) begin
               mem_q[mem_waddr][li*LANE_BITS +: LANE_BITS] <= mem_wdata[li*LANE_BITS +: LANE_BITS];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read port
   // ------------------------------------------------------------------
   assign rd_word = mem_q[rd_addr];

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_merge
         assign rd_merged[gi*LANE_BITS +: LANE_BITS] = wr_mask[gi]
                                                     ? wr_data[gi*LANE_BITS +: LANE_BITS]
                                                     : rd_word[gi*LANE_BITS +: LANE_BITS];
      end
   endgenerate

   assign bypass_hit = BYPASS && wr_en && (wr_addr == rd_addr);

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (port_active && rd_en) begin
         rd_valid_d = 1'b1;
         rd_data_d  = bypass_hit ? rd_merged : rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Parametrised single-clock memory with one write port and one registered read port. Adds per-lane write masking, a selectable read-during-write policy and a built-in clear sequencer that fills every word with a constant after reset or on request. It is the general-purpose data/register-file store for the processor datapath, and it supersedes the fixed-width combinational-read RAM.

## Interface

Parameters:
- ADDR_BITS, 8, address width; depth N = 2**ADDR_BITS.
- DATA_BITS, 8, word width.
- LANES, 1, write-mask lanes. DATA_BITS must be divisible by LANES. LANE_BITS = DATA_BITS/LANES.
- BYPASS, 1, read-during-write policy to the same address: 1 returns the new (merged) data, 0 returns the old data.
- CLEAR_VALUE, 0, DATA_BITS-wide word written by the clear sequencer.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_start  in  1  request a full clear; sampled only in READY.
- busy  out  1  high while the clear sequence runs.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  DATA_BITS  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_BITS  write data.
- wr_mask  in  LANES  lane i writes bits [i*LANE_BITS +: LANE_BITS] when set.

## Operation

- The FSM has two states, CLEAR and READY. It also holds a clear pointer clr_addr of ADDR_BITS bits.
- Reset, at any time and from any state:
  - state goes to CLEAR, clr_addr to 0;
  - busy=1, rd_valid=0, rd_data=0.
  - Memory contents are not touched by reset itself; the clear sequence that follows overwrites them.
- CLEAR:
  - Each cycle writes CLEAR_VALUE (all lanes) to clr_addr, then increments clr_addr.
  - On the cycle that writes address N-1, the next state is READY and clr_addr wraps to 0.
  - rd_en, wr_en and clr_start are ignored. No memory write from the ports occurs, and rd_valid stays 0.
- READY:
  - busy=0.
  - clr_start=1 moves the FSM to CLEAR with clr_addr=0. Any rd_en/wr_en in that same cycle are still serviced normally.
- Write (READY, wr_en=1): each lane with its wr_mask bit set is updated. Lanes with a clear mask bit keep their value. wr_mask=0 is a legal no-op.
- Read (READY, rd_en=1): rd_data <= memory[rd_addr], and rd_valid <= 1 for one cycle.
  - When rd_en=0, rd_valid <= 0 and rd_data holds its previous value.
- Read and write in the same cycle, same address:
  - BYPASS=1: rd_data gets, per lane, wr_data where the mask is set and the old word elsewhere.
  - BYPASS=0: rd_data gets the old word.
  - Different addresses: the two ports are fully independent.
- A clr_start arriving while busy is dropped; the sequence is not restarted. Reset is the only way to restart a clear in progress.

## Timing

- Reset asserted at edge E0 and released before E1: clear writes occur at edges E1..EN.
  - busy=1 from E0 through EN; busy=0 after edge EN.
  - The first port access is accepted at edge EN+1.
- Clear length is exactly N cycles from either reset or clr_start. If clr_start is sampled at edge S, the clear writes occur at S+1..S+N.
- Read latency is 1: address sampled at edge E, rd_data/rd_valid valid after E. Back-to-back reads give one word per cycle.
- A write at edge E is visible to a non-bypassed read sampled at edge E+1 or later.
- Outputs after reset: busy=1, rd_valid=0, rd_data=0.

## Test plan

- ADDR_BITS=4, CLEAR_VALUE=8'hA5: pulse rst for 1 cycle -> busy high for exactly 16 cycles. Then reading addresses 0..15 returns 8'hA5 each, with rd_valid high one cycle after each rd_en.
- DATA_BITS=16, LANES=2, word 0x1234 at address 3: write 0xABCD with wr_mask=2'b10 -> read of address 3 returns 0xAB34.
- Same-address read and write, old word 0x11, write 0x22:
  - BYPASS=1 -> rd_data=0x22;
  - BYPASS=0 -> rd_data=0x11, and the next read returns 0x22.
- After writing 0x5A to address 7: assert clr_start together with a read of address 7 -> that read returns 0x5A. Then busy=1 for 16 cycles, rd_en/wr_en are ignored (rd_valid=0, no write lands), and address 7 then reads CLEAR_VALUE.
- Assert rst when clr_addr=9 mid-clear -> clr_addr restarts at 0, and busy stays high a full 16 cycles counted from the reset edge.
- With busy=1: assert clr_start -> no extension; busy drops at the original cycle.
